// File: rtl/ryu_pkg.sv
// Shared types and constants for the Ryu motion/animation controller.
// Sprite codes match the renderer's 3-bit select; keycodes are USB HID usages.
package ryu_pkg;

    typedef enum logic [1:0] {
        STAND = 2'd0,
        PUNCH = 2'd1,
        JUMP  = 2'd2
    } ryu_state_t;

    localparam logic [2:0] SPR_STAND = 3'd0;
    localparam logic [2:0] SPR_PUNCH = 3'd1;
    localparam logic [2:0] SPR_JUMP  = 3'd2;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_J = 8'h0D;

    // Saturate an 11-bit signed coordinate into the unsigned window [lo, hi].
    function automatic logic [9:0] clamp_u10(
        input logic signed [10:0] v,
        input logic        [9:0]  lo,
        input logic        [9:0]  hi
    );
        logic signed [10:0] lo_s;
        logic signed [10:0] hi_s;
        lo_s = $signed({1'b0, lo});
        hi_s = $signed({1'b0, hi});
        if (v < lo_s)
            return lo;
        else if (v > hi_s)
            return hi;
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/ryu_frame_tick.sv
// Falling-edge detector on active-low vsync; emits one registered pulse per frame.
module frame_tick (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic vs,
    output logic tick
);

    logic r_vs_prev;
    logic r_tick;

    // r_vs_prev resets high so a vs held low through reset is not seen as an edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_vs_prev <= vs;
            r_tick    <= r_vs_prev & ~vs;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/ryu_controller.sv
// Per-frame stand/punch/jump controller driving the sprite renderer's position and select.
// All state advances only on the frame tick, so outputs never change mid-frame.
module ryu_controller
    import ryu_pkg::*;
#(
    parameter logic [9:0] X_START      = 10'd100,
    parameter logic [9:0] X_MIN        = 10'd0,
    parameter logic [9:0] X_MAX        = 10'd560,
    parameter logic [9:0] GROUND_Y     = 10'd300,
    parameter int         STEP         = 4,
    parameter int         PUNCH_FRAMES = 12,
    parameter int         JUMP_VEL     = 15,
    parameter int         GRAVITY      = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic [7:0] keycode,
    output logic [9:0] RyuX,
    output logic [9:0] RyuY,
    output logic [2:0] sprite
);

    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [5:0]  JUMP_VY  = 6'(-JUMP_VEL);
    localparam logic signed [5:0]  GRAV_S   = 6'(GRAVITY);
    localparam logic        [7:0]  CNT_LOAD = 8'(PUNCH_FRAMES - 1);
    localparam logic signed [10:0] GROUND_S = $signed({1'b0, GROUND_Y});

    logic w_tick;

    ryu_state_t         r_state;
    logic        [9:0]  r_x;
    logic        [9:0]  r_y;
    logic        [2:0]  r_sprite;
    logic        [7:0]  r_cnt;
    logic signed [5:0]  r_vy;
    logic        [7:0]  r_prev_key;

    logic               w_press_new;
    logic               w_punch_go;
    logic               w_jump_go;
    logic signed [10:0] w_x_sum;
    logic        [9:0]  w_x_walk;
    logic signed [10:0] w_y_sum;
    logic               w_land;
    logic        [9:0]  w_y_air;

    frame_tick u_frame_tick (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vs      (vs),
        .tick    (w_tick)
    );

    // Punch and jump are edge-triggered against the keycode seen on the previous tick.
    assign w_press_new = (keycode != r_prev_key);
    assign w_punch_go  = (keycode == KEY_J) && w_press_new;
    assign w_jump_go   = (keycode == KEY_W) && w_press_new;

    always_comb begin
        w_x_sum = $signed({1'b0, r_x});
        if (keycode == KEY_A)
            w_x_sum = w_x_sum - STEP_S;
        else if (keycode == KEY_D)
            w_x_sum = w_x_sum + STEP_S;
    end

    assign w_x_walk = clamp_u10(w_x_sum, X_MIN, X_MAX);

    // Landing is judged on the un-clamped sum; the top-of-screen clamp only limits Y, not vy.
    assign w_y_sum = $signed({1'b0, r_y}) + $signed({{5{r_vy[5]}}, r_vy});
    assign w_land  = (w_y_sum >= GROUND_S);
    assign w_y_air = w_y_sum[10] ? 10'd0 : w_y_sum[9:0];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= STAND;
            r_x        <= X_START;
            r_y        <= GROUND_Y;
            r_sprite   <= SPR_STAND;
            r_cnt      <= 8'd0;
            r_vy       <= 6'sd0;
            r_prev_key <= 8'h00;
        end else if (w_tick) begin
            r_prev_key <= keycode;
            case (r_state)
                STAND: begin
                    if (w_punch_go) begin
                        r_state  <= PUNCH;
                        r_sprite <= SPR_PUNCH;
                        r_cnt    <= CNT_LOAD;
                    end else if (w_jump_go) begin
                        r_state  <= JUMP;
                        r_sprite <= SPR_JUMP;
                        r_vy     <= JUMP_VY;
                    end else begin
                        r_x <= w_x_walk;
                    end
                end
                PUNCH: begin
                    if (r_cnt == 8'd0) begin
                        r_state  <= STAND;
                        r_sprite <= SPR_STAND;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                JUMP: begin
                    r_x <= w_x_walk;
                    if (w_land) begin
                        r_y      <= GROUND_Y;
                        r_vy     <= 6'sd0;
                        r_state  <= STAND;
                        r_sprite <= SPR_STAND;
                    end else begin
                        r_y  <= w_y_air;
                        r_vy <= r_vy + GRAV_S;
                    end
                end
                default: begin
                    r_state  <= STAND;
                    r_sprite <= SPR_STAND;
                end
            endcase
        end
    end

    assign RyuX   = r_x;
    assign RyuY   = r_y;
    assign sprite = r_sprite;

endmodule
